// File: rtl/voice_allocator.sv
// voice_allocator: polyphony controller. A scan pointer visits one key per
// cycle; a newly pressed key gets the lowest free voice (or steals the oldest
// allocation when all voices sound), a released key frees its voice.
// All outputs are registered; voice_load and steal are one-cycle pulses that
// coincide with the first cycle the new voice values are visible.
module voice_allocator #(
    parameter int NUM_KEYS   = 13,
    parameter int NUM_VOICES = 4,
    parameter int PW         = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_KEYS-1:0]              key_down,
    input  logic [2:0]                       scale,
    output logic [NUM_VOICES-1:0][PW-1:0]    voice_half_period,
    output logic [NUM_VOICES-1:0][3:0]       voice_key,
    output logic [NUM_VOICES-1:0]            voice_active,
    output logic [NUM_VOICES-1:0]            voice_load,
    output logic                             steal,
    // Per-key state for observation: 0 = IDLE, 1 = SOUNDING, 2 = STOLEN.
    output logic [NUM_KEYS-1:0][1:0]         dbg_key_state
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [3:0] LAST_KEY = 4'(NUM_KEYS - 1);
    localparam logic [VW-1:0] OLDEST_RANK = VW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        K_IDLE     = 2'd0,
        K_SOUNDING = 2'd1,
        K_STOLEN   = 2'd2
    } key_state_e;

    // Base half-period counts at scale 0, one entry per key.
    function automatic logic [17:0] note_base(input logic [3:0] k);
        case (k)
            4'd0:    note_base = 18'd191113;
            4'd1:    note_base = 18'd180387;
            4'd2:    note_base = 18'd170262;
            4'd3:    note_base = 18'd160706;
            4'd4:    note_base = 18'd151686;
            4'd5:    note_base = 18'd143173;
            4'd6:    note_base = 18'd135137;
            4'd7:    note_base = 18'd127553;
            4'd8:    note_base = 18'd120394;
            4'd9:    note_base = 18'd113636;
            4'd10:   note_base = 18'd107258;
            4'd11:   note_base = 18'd101238;
            4'd12:   note_base = 18'd95556;
            default: note_base = 18'd0;
        endcase
    endfunction

    // Scan front end
    logic [NUM_KEYS-1:0] key_q;
    logic [3:0]          ptr_q, ptr_d;

    // Key and voice state
    key_state_e                    key_state_q [NUM_KEYS];
    key_state_e                    key_state_d [NUM_KEYS];
    logic [NUM_VOICES-1:0][PW-1:0] hp_q, hp_d;
    logic [NUM_VOICES-1:0][3:0]    vkey_q, vkey_d;
    logic [NUM_VOICES-1:0]         active_q, active_d;
    logic [NUM_VOICES-1:0]         load_q, load_d;
    logic                          steal_q, steal_d;
    // Rank 0 = most recently allocated. Active voices always hold the ranks
    // 0..(active count - 1) in allocation order, so the oldest sounding voice
    // carries the highest rank.
    logic [VW-1:0]                 rank_q [NUM_VOICES];
    logic [VW-1:0]                 rank_d [NUM_VOICES];

    // Decode helpers
    logic          cur_key;
    key_state_e    cur_state;
    logic          free_found;
    logic [VW-1:0] free_idx;
    logic [VW-1:0] lru_idx;
    logic [VW-1:0] lru_rank;
    logic          own_found;
    logic [VW-1:0] own_idx;
    logic [VW-1:0] alloc_idx;
    logic [VW-1:0] old_rank;

    // Pointer wraps after the last key.
    always_comb begin
        ptr_d = (ptr_q == LAST_KEY) ? 4'd0 : ptr_q + 4'd1;
    end

    // Input register and scan pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= '0;
            ptr_q <= '0;
        end else begin
            key_q <= key_down;
            ptr_q <= ptr_d;
        end
    end

    // Voice search: lowest free voice, oldest active voice, and the voice owned by the scanned key.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = VW'(i);
            end
        end

        lru_idx  = '0;
        lru_rank = rank_q[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (rank_q[i] > lru_rank) begin
                lru_idx  = VW'(i);
                lru_rank = rank_q[i];
            end
        end

        own_found = 1'b0;
        own_idx   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && (vkey_q[i] == ptr_q)) begin
                own_found = 1'b1;
                own_idx   = VW'(i);
            end
        end

        alloc_idx = free_found ? free_idx : lru_idx;
        old_rank  = free_found ? OLDEST_RANK : rank_q[alloc_idx];
    end

    // Per-key state machine next state plus voice allocation / free actions.
    always_comb begin
        key_state_d = key_state_q;
        hp_d        = hp_q;
        vkey_d      = vkey_q;
        active_d    = active_q;
        rank_d      = rank_q;
        load_d      = '0;
        steal_d     = 1'b0;
        cur_key     = key_q[ptr_q];
        cur_state   = key_state_q[ptr_q];

        case (cur_state)
            K_IDLE: begin
                if (cur_key) begin
                    key_state_d[ptr_q] = K_SOUNDING;
                    if (!free_found) begin
                        // The evicted key must be released before it can sound again.
                        key_state_d[vkey_q[alloc_idx]] = K_STOLEN;
                        steal_d = 1'b1;
                    end
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if ((VW'(i) != alloc_idx) && active_q[i] && (rank_q[i] < old_rank)) begin
                            rank_d[i] = rank_q[i] + 1'b1;
                        end
                    end
                    rank_d[alloc_idx]   = '0;
                    active_d[alloc_idx] = 1'b1;
                    vkey_d[alloc_idx]   = ptr_q;
                    hp_d[alloc_idx]     = PW'(note_base(ptr_q)) >> scale;
                    load_d[alloc_idx]   = 1'b1;
                end
            end
            K_SOUNDING: begin
                if (!cur_key) begin
                    key_state_d[ptr_q] = K_IDLE;
                    if (own_found) begin
                        active_d[own_idx] = 1'b0;
                        // Close the gap so active ranks stay dense and distinct.
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (active_q[i] && (rank_q[i] > rank_q[own_idx])) begin
                                rank_d[i] = rank_q[i] - 1'b1;
                            end
                        end
                    end
                end
            end
            K_STOLEN: begin
                if (!cur_key) begin
                    key_state_d[ptr_q] = K_IDLE;
                end
            end
            default: begin
                key_state_d[ptr_q] = K_IDLE;
            end
        endcase
    end

    // Key states, voice registers, ranks and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_state_q[k] <= K_IDLE;
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= VW'(i);
            end
            hp_q     <= '0;
            vkey_q   <= '0;
            active_q <= '0;
            load_q   <= '0;
            steal_q  <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            rank_q      <= rank_d;
            hp_q        <= hp_d;
            vkey_q      <= vkey_d;
            active_q    <= active_d;
            load_q      <= load_d;
            steal_q     <= steal_d;
        end
    end

    // Output drive and state observation.
    always_comb begin
        voice_half_period = hp_q;
        voice_key         = vkey_q;
        voice_active      = active_q;
        voice_load        = load_q;
        steal             = steal_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            dbg_key_state[k] = key_state_q[k];
        end
    end

endmodule
